// File: rtl/bft_leaf_interface.sv
// bft_leaf_interface
// Leaf endpoint of the butterfly fat-tree. It connects one processing element
// to a level-0 switch port.
//
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   bus_i         packet from the switch: {valid, dest[AW-1:0], payload}
//   bus_o         registered packet to the switch. It is all-zero when idle.
//   tx_valid/tx_ready/tx_dest/tx_payload
//                 PE injection port. It feeds the TX FIFO.
//   rx_valid/rx_ready/rx_payload
//                 PE ejection port. The RX FIFO head is presented
//                 first-word fall-through.
//   bounce_cnt    saturating count of packets re-injected onto bus_o
//
// Packets addressed elsewhere are re-injected onto bus_o. Packets for this leaf
// that find the RX FIFO full are also re-injected. Re-injected packets take
// priority over TX traffic.

module bft_leaf_fifo #(
  parameter int unsigned width      = 8,
  parameter int unsigned log2_depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] din,
  input  logic             pop,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned depth = 2 ** log2_depth;

  logic [width-1:0]    mem [depth];
  logic [log2_depth:0] wr_ptr;
  logic [log2_depth:0] rd_ptr;
  logic                push_en;
  logic                pop_en;

  // Both status flags come from the registered pointers. A pop in the same
  // cycle therefore never frees space for a push.
  assign full  = (wr_ptr[log2_depth] != rd_ptr[log2_depth]) &&
                 (wr_ptr[log2_depth-1:0] == rd_ptr[log2_depth-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  assign dout = mem[rd_ptr[log2_depth-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr[log2_depth-1:0]] <= din;
  end

endmodule

module bft_leaf_interface #(
  parameter int unsigned num_leaves = 256,
  parameter int unsigned payload_sz = 43,
  parameter int unsigned p_sz       = 52,
  parameter int unsigned addr       = 0,
  parameter int unsigned fifo_log2  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [p_sz-1:0]               bus_i,
  output logic [p_sz-1:0]               bus_o,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [$clog2(num_leaves)-1:0] tx_dest,
  input  logic [payload_sz-1:0]         tx_payload,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [payload_sz-1:0]         rx_payload,
  output logic [15:0]                   bounce_cnt
);

  localparam int unsigned AW   = $clog2(num_leaves);
  localparam int unsigned TX_W = AW + payload_sz;
  localparam logic [AW-1:0] leaf_addr = AW'(addr);

  logic                  in_valid;
  logic [AW-1:0]         in_dest;
  logic [payload_sz-1:0] in_payload;
  logic                  dest_match;
  logic                  reinject;

  logic                  tx_push;
  logic                  tx_pop;
  logic [TX_W-1:0]       tx_head;
  logic                  tx_full;
  logic                  tx_empty;

  logic                  rx_push;
  logic                  rx_pop;
  logic                  rx_full;
  logic                  rx_empty;

  assign in_valid   = bus_i[p_sz-1];
  assign in_dest    = bus_i[p_sz-2:payload_sz];
  assign in_payload = bus_i[payload_sz-1:0];
  assign dest_match = (in_dest == leaf_addr);

  // A matching packet bounces when RX is already full. This holds even if the
  // PE pops in this same cycle.
  assign rx_push  = in_valid && dest_match && !rx_full;
  assign reinject = in_valid && (!dest_match || rx_full);

  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && !tx_full;
  assign tx_pop   = !reinject && !tx_empty;

  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_ready && !rx_empty;

  bft_leaf_fifo #(
    .width      (TX_W),
    .log2_depth (fifo_log2)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .din   ({tx_dest, tx_payload}),
    .pop   (tx_pop),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  bft_leaf_fifo #(
    .width      (payload_sz),
    .log2_depth (fifo_log2)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .din   (in_payload),
    .pop   (rx_pop),
    .dout  (rx_payload),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // At most one packet arrives per cycle, so a re-inject always has the output
  // slot. TX traffic waits while deflections continue.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_o      <= '0;
      bounce_cnt <= '0;
    end else begin
      if (reinject) begin
        bus_o <= bus_i;
        if (bounce_cnt != '1) bounce_cnt <= bounce_cnt + 16'd1;
      end else if (!tx_empty) begin
        bus_o <= {1'b1, tx_head};
      end else begin
        bus_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bft_leaf_interface.sv
// Self-checking bench for bft_leaf_interface with its default parameters
// (256 leaves, 43-bit payload, addr 0, 16-entry FIFOs).

module tb_bft_leaf_interface;

  localparam int PS = 43;
  localparam int PW = 52;
  localparam logic [7:0] ADDR = 8'h00;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] bus_i;
  logic [PW-1:0] bus_o;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    tx_dest;
  logic [PS-1:0] tx_payload;
  logic          rx_valid;
  logic          rx_ready;
  logic [PS-1:0] rx_payload;
  logic [15:0]   bounce_cnt;

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  bft_leaf_interface dut (
    .clk        (clk),
    .reset      (reset),
    .bus_i      (bus_i),
    .bus_o      (bus_o),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_dest    (tx_dest),
    .tx_payload (tx_payload),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_payload (rx_payload),
    .bounce_cnt (bounce_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. The FIFOs are plain queues. Each packet is classified
  // and routed from the leaf's routing rules.
  logic [PS+7:0] tx_q[$];
  logic [PS-1:0] rx_q[$];
  logic [PW-1:0] m_bus;
  int            m_cnt;

  always @(posedge clk) begin
    int  tsz;
    int  rsz;
    bit  bounce;
    bit  rx_in;
    if (reset) begin
      tx_q.delete();
      rx_q.delete();
      m_bus = '0;
      m_cnt = 0;
    end else begin
      tsz    = tx_q.size();
      rsz    = rx_q.size();
      bounce = 1'b0;
      rx_in  = 1'b0;
      if (bus_i[PW-1]) begin
        if (bus_i[PW-2:PS] == ADDR && rsz < 16) rx_in = 1'b1;
        else bounce = 1'b1;
      end
      if (bounce) begin
        m_bus = bus_i;
        if (m_cnt < 65535) m_cnt++;
      end else if (tsz > 0) begin
        m_bus = {1'b1, tx_q.pop_front()};
      end else begin
        m_bus = '0;
      end
      if (rx_ready && rsz > 0) void'(rx_q.pop_front());
      if (rx_in) rx_q.push_back(bus_i[PS-1:0]);
      if (tx_valid && tsz < 16) tx_q.push_back({tx_dest, tx_payload});
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_bus_o", bus_o, m_bus);
      chk("m_tx_ready", tx_ready, tx_q.size() < 16);
      chk("m_rx_valid", rx_valid, rx_q.size() > 0);
      if (rx_q.size() > 0) chk("m_rx_payload", rx_payload, rx_q[0]);
      chk("m_bounce_cnt", bounce_cnt, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_i      = '0;
    tx_valid   = 1'b0;
    tx_dest    = '0;
    tx_payload = '0;
    rx_ready   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [PW-1:0] pkt(input logic [7:0] d, input logic [PS-1:0] p);
    return {1'b1, d, p};
  endfunction

  initial begin
    int n;
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    cmp_on = 1'b1;
    chk("rst_bus_o", bus_o, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_bounce", bounce_cnt, 0);

    // Basic TX with a two-cycle latency.
    tx_valid = 1'b1; tx_dest = 8'h05; tx_payload = 43'h123;
    tick();
    tx_valid = 1'b0;
    chk("tx_not_yet", bus_o, 0);
    tick();
    chk("tx_out", bus_o, pkt(8'h05, 43'h123));
    tick();
    chk("tx_one_cycle", bus_o, 0);

    // RX capture.
    bus_i = pkt(8'h00, 43'h7AB);
    tick();
    bus_i = '0;
    chk("rx_valid", rx_valid, 1);
    chk("rx_payload", rx_payload, 43'h7AB);
    chk("rx_no_bus", bus_o, 0);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("rx_drained", rx_valid, 0);

    // A deflection takes priority over queued TX traffic.
    do_reset();
    tx_valid = 1'b1; tx_dest = 8'h0A; tx_payload = 43'hAAA;
    tick();
    tx_dest = 8'h0B; tx_payload = 43'hBBB; bus_i = pkt(8'h03, 43'h1);
    tick();
    tx_valid = 1'b0; bus_i = '0;
    chk("defl_out", bus_o, pkt(8'h03, 43'h1));
    chk("defl_cnt", bounce_cnt, 1);
    tick();
    chk("defl_tx_a", bus_o, pkt(8'h0A, 43'hAAA));
    tick();
    chk("defl_tx_b", bus_o, pkt(8'h0B, 43'hBBB));
    tick();
    chk("defl_idle", bus_o, 0);

    // Bounce on a full RX FIFO, even with a same-cycle pop.
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      bus_i = pkt(8'h00, PS'(i));
      tick();
    end
    bus_i = pkt(8'h00, 43'h17);
    rx_ready = 1'b1;
    tick();
    bus_i = '0; rx_ready = 1'b0;
    chk("rxfull_bounce", bus_o, pkt(8'h00, 43'h17));
    chk("rxfull_cnt", bounce_cnt, 1);
    chk("rxfull_head", rx_payload, 2);
    n = 0;
    rx_ready = 1'b1;
    for (int k = 0; k < 40 && rx_valid; k++) begin
      tick();
      n++;
    end
    rx_ready = 1'b0;
    chk("rxfull_count", n, 15);

    // TX backpressure while a deflected stream holds the output.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      chk("bp_ready", tx_ready, 1);
      tx_valid = 1'b1; tx_dest = 8'h10 + 8'(i); tx_payload = PS'(100 + i);
      bus_i = pkt(8'h42, PS'(i));
      tick();
    end
    chk("bp_full", tx_ready, 0);
    tx_valid = 1'b0; bus_i = '0;
    tick();
    chk("bp_first", bus_o, pkt(8'h10, PS'(100)));
    chk("bp_ready_back", tx_ready, 1);
    for (int j = 1; j < 16; j++) begin
      tick();
      chk("bp_order", bus_o, pkt(8'h10 + 8'(j), PS'(100 + j)));
    end
    tick();
    chk("bp_idle", bus_o, 0);
    chk("bp_cnt", bounce_cnt, 16);

    // Reset with both FIFOs half full.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus_i = pkt(8'h00, PS'(i + 50));
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      tx_valid = 1'b1; tx_dest = 8'h20; tx_payload = PS'(i);
      bus_i = pkt(8'h77, PS'(i));
      tick();
    end
    reset = 1'b1;
    bus_i = pkt(8'h00, 43'h55);
    tick();
    reset = 1'b0;
    idle_inputs();
    chk("mr_bus_o", bus_o, 0);
    chk("mr_tx_ready", tx_ready, 1);
    chk("mr_rx_valid", rx_valid, 0);
    chk("mr_bounce", bounce_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mr_no_stale", bus_o, 0);
    end

    tick();
    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bft_leaf_interface.md
# bft_leaf_interface

Leaf-side endpoint of the butterfly fat-tree network. It sits directly below a level-0 `pi_switch_top` port and connects one processing element (PE) to the tree. It buffers PE-issued packets in a TX FIFO and injects them onto the switch-facing bus. Packets addressed to this leaf are captured into an RX FIFO. Deflected (misrouted) packets and packets that cannot be accepted are re-injected with priority over new traffic.

## Interface
Parameters:
- `num_leaves`, 256, leaves in the tree; `AW = log2(num_leaves)` = 8
- `payload_sz`, 43, payload bits
- `p_sz`, 52, packet width; must equal `1 + AW + payload_sz`
- `addr`, 0, this leaf's address
- `fifo_log2`, 4, log2 depth of each FIFO (16 entries)

Packet format: bit `[p_sz-1]` valid, bits `[p_sz-2:payload_sz]` destination address, bits `[payload_sz-1:0]` payload. A packet with valid = 0 is idle; an idle packet is all-zero on output.

Ports (reset is `reset`, synchronous, active-high; clock is `clk`):
- `clk`, in, 1, clock
- `reset`, in, 1, synchronous active-high reset
- `bus_i`, in, p_sz, packet from the switch (down-link)
- `bus_o`, out, p_sz, registered packet to the switch (up-link)
- `tx_valid`, in, 1, PE offers a packet
- `tx_ready`, out, 1, TX FIFO not full
- `tx_dest`, in, AW, destination leaf
- `tx_payload`, in, payload_sz, payload
- `rx_valid`, out, 1, RX FIFO not empty
- `rx_ready`, in, 1, PE consumes head
- `rx_payload`, out, payload_sz, RX head payload (first-word fall-through)
- `bounce_cnt`, out, 16, saturating count of re-injected packets

## Operation
- TX push: on `tx_valid && tx_ready`, `{tx_dest, tx_payload}` is written to the TX FIFO. `tx_ready = !tx_full`.
- Incoming classification each cycle, when `bus_i[p_sz-1]` = 1:
  - Destination == `addr` and RX not full → write the payload to the RX FIFO.
  - Destination == `addr` and RX full → re-inject (bounce).
  - Destination != `addr` → re-inject (deflected packet).
- RX fullness is evaluated before a same-cycle pop. A packet arriving while RX is full bounces even if `rx_ready` pops an entry in that cycle.
- Output selection, one packet per cycle:
  1. Re-inject: `bus_o <= bus_i` unchanged. The TX FIFO is not popped.
  2. Else, if the TX FIFO is not empty: `bus_o <= {1'b1, head}` and pop.
  3. Else: `bus_o <= 0`.
- Since at most one packet arrives per cycle, a re-inject always has a slot. TX traffic can starve while deflections persist; this is intended.
- `bounce_cnt` increments on every re-inject and saturates at 16'hFFFF.
- RX pop: on `rx_valid && rx_ready`, the head advances. `rx_payload` is undefined when `rx_valid` = 0.
- FIFOs: each uses read/write pointers of width `fifo_log2+1`, wrapping modulo the depth.
  - Full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
  - Simultaneous push and pop on a non-empty, non-full FIFO keeps the occupancy unchanged.

## Timing
- Reset values: `bus_o` = 0, `tx_ready` = 1, `rx_valid` = 0, `bounce_cnt` = 0. Both FIFOs are empty.
- Reset asserted mid-operation discards all buffered packets. The packet on `bus_i` during reset is dropped, not bounced.
- TX latency: a push accepted at edge t appears on `bus_o` after edge t+1, provided there is no contention and the FIFO was empty. Minimum 2 cycles from `tx_valid` to `bus_o`.
- RX latency: `bus_i` valid and matching at edge t → `rx_valid` = 1 after edge t.
- Re-inject latency: `bus_i` at edge t → identical packet on `bus_o` after edge t (1 cycle).
- Throughput: one TX packet per cycle when there are no re-injects. One RX packet per cycle.

## Test plan
- Reset, then push dest = 8'h05, payload = 43'h123 with `addr` = 0 → after 2 cycles `bus_o` = `{1, 8'h05, 43'h123}` for exactly one cycle, then 0.
- `bus_i` = `{1, 8'h00, 43'h7AB}` with `rx_ready` = 0 → `rx_valid` = 1 and `rx_payload` = 43'h7AB on the next cycle; no bus output.
- `bus_i` = `{1, 8'h03, 43'h1}` while the TX FIFO holds 2 packets → `bus_o` = that packet the next cycle, the TX packets follow on the two subsequent cycles, and `bounce_cnt` = 1.
- Fill RX with 16 matching packets (`rx_ready` = 0), send a 17th while asserting `rx_ready` the same cycle → the 17th is bounced to `bus_o`, RX ends with 15 entries, and `bounce_cnt` = 1.
- Push 16 TX packets while `bus_i` carries a continuous deflected stream → `tx_ready` = 0 after the 16th push. Release the stream → `tx_ready` = 1 one cycle after the first pop, and all 16 packets exit in order.
- Assert `reset` with both FIFOs half full → all outputs return to their reset values next cycle, and no stale packet appears on `bus_o` afterwards.
